// File: rtl/sync_pkg.sv
// Shared defaults and helpers for the multi-bit synchronizer / glitch filter.
package sync_pkg;

  localparam int SYNC_DEF_STAGES = 2;
  localparam int SYNC_DEF_STABLE = 4;

  // Width of a counter that must be able to hold values up to 'stable'.
  function automatic int sync_cnt_w(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/sync_bit_filter.sv
// Single-bit stability filter with registered rise/fall pulses.
// Only built when SYNC_GLITCH_FILTER_EN is defined.
`ifdef SYNC_GLITCH_FILTER_EN
module sync_bit_filter
  import sync_pkg::*;
#(
  parameter int   STABLE_CYCLES = SYNC_DEF_STABLE,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic dest_clk,
  input  logic dest_reset_n,
  input  logic i_sync,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = sync_cnt_w(STABLE_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_filt;
  logic          r_rise;
  logic          r_fall;
  logic          w_update;

  // A new value is accepted on the STABLE_CYCLES-th consecutive differing cycle.
  assign w_update = (i_sync != r_filt) && (r_cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      r_cnt  <= '0;
      r_filt <= RESET_VALUE;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_update & i_sync;
      r_fall <= w_update & ~i_sync;
      if (i_sync == r_filt) begin
        r_cnt <= '0;
      end else if (w_update) begin
        r_filt <= i_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_filt;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule
`endif

// File: rtl/sync_filter_array.sv
// Multi-bit N-stage synchronizer with per-bit edge pulses; the per-bit glitch
// filter is compiled in with SYNC_GLITCH_FILTER_EN.
module sync_filter_array
  import sync_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 3,
  parameter int                    STAGES        = SYNC_DEF_STAGES,
  parameter int                    STABLE_CYCLES = SYNC_DEF_STABLE,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                  dest_clk,
  input  logic                  dest_reset_n,
  input  logic [DATA_WIDTH-1:0] async_data_i,
  output logic [DATA_WIDTH-1:0] sync_data_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter_array: STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("sync_filter_array: STABLE_CYCLES must be at least 1");
  end

  logic [DATA_WIDTH-1:0] r_chain [STAGES];
  logic [DATA_WIDTH-1:0] w_s;

  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_chain[k] <= RESET_VALUE;
      end
    end else begin
      r_chain[0] <= async_data_i;
      for (int k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign w_s = r_chain[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
  logic [DATA_WIDTH-1:0] w_level;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    sync_bit_filter #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_filter (
      .dest_clk     (dest_clk),
      .dest_reset_n (dest_reset_n),
      .i_sync       (w_s[i]),
      .o_level      (w_level[i]),
      .o_rise       (w_rise[i]),
      .o_fall       (w_fall[i])
    );
  end

  assign sync_data_o = w_level;
  assign rise_o      = w_rise;
  assign fall_o      = w_fall;
`else
  logic [DATA_WIDTH-1:0] r_rise;
  logic [DATA_WIDTH-1:0] r_fall;

  // Pulses look one stage ahead so they coincide with the change on w_s.
  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= r_chain[STAGES-2] & ~w_s;
      r_fall <= ~r_chain[STAGES-2] & w_s;
    end
  end

  assign sync_data_o = w_s;
  assign rise_o      = r_rise;
  assign fall_o      = r_fall;
`endif

endmodule

// File: tb/tb_sync_filter_array.sv
// Directed bench for sync_filter_array; expectations adapt to whether
// SYNC_GLITCH_FILTER_EN is defined.
module tb_sync_filter_array;

`ifdef SYNC_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif
  localparam int LAT_DEF   = FILTER_ON ? 6 : 2;
  localparam int LAT_S3    = FILTER_ON ? 7 : 3;
  localparam int GRAY_HOLD = FILTER_ON ? 8 : 1;
  localparam int RST_AT    = FILTER_ON ? 4 : 1;

  logic       clock;
  logic       resetN;
  logic [2:0] inRv, inDef, inS3;
  logic [2:0] syncRv, riseRv, fallRv;
  logic [2:0] syncDef, riseDef, fallDef;
  logic [2:0] syncS3, riseS3, fallS3;

  int passCount;
  int failCount;
  int checkCount;

  sync_filter_array #(.DATA_WIDTH(3), .RESET_VALUE(3'b101)) uRv (
    .dest_clk(clock), .dest_reset_n(resetN), .async_data_i(inRv),
    .sync_data_o(syncRv), .rise_o(riseRv), .fall_o(fallRv)
  );

  sync_filter_array #(.DATA_WIDTH(3)) uDef (
    .dest_clk(clock), .dest_reset_n(resetN), .async_data_i(inDef),
    .sync_data_o(syncDef), .rise_o(riseDef), .fall_o(fallDef)
  );

  sync_filter_array #(.DATA_WIDTH(3), .STAGES(3)) uS3 (
    .dest_clk(clock), .dest_reset_n(resetN), .async_data_i(inS3),
    .sync_data_o(syncS3), .rise_o(riseS3), .fall_o(fallS3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int unitSel, input logic [2:0] value);
    case (unitSel)
      0:       inRv  = value;
      1:       inDef = value;
      default: inS3  = value;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] observed,
                             input logic [2:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Pulse of 'width' cycles on uDef; rejected by the filter when too short.
  task automatic runPulse(input logic [2:0] mask, input int width);
    bit accepted;
    accepted = !FILTER_ON || (width >= 4);
    applyStimulus(1, mask);
    for (int e = 1; e <= LAT_DEF + width + 3; e++) begin
      tick();
      if (e == width) applyStimulus(1, 3'b000);
      checkOutput($sformatf("pulse%0d sync e%0d", width, e), syncDef,
                  (accepted && e >= LAT_DEF && e < LAT_DEF + width) ? mask : 3'b000);
      checkOutput($sformatf("pulse%0d rise e%0d", width, e), riseDef,
                  (accepted && e == LAT_DEF) ? mask : 3'b000);
      checkOutput($sformatf("pulse%0d fall e%0d", width, e), fallDef,
                  (accepted && e == LAT_DEF + width) ? mask : 3'b000);
    end
  endtask

  function automatic logic [2:0] grayIn(input int e);
    int idx;
    if (e < 1) return 3'b000;
    idx = (e - 1) / GRAY_HOLD;
    case (idx)
      0:       return 3'b001;
      1:       return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  initial begin
    logic [2:0] expNow, expPrev;
    passCount  = 0;
    failCount  = 0;
    checkCount = 0;
    resetN = 1'b0;
    inRv   = 3'b101;
    inDef  = 3'b000;
    inS3   = 3'b000;

    // Reset values, including a non-zero RESET_VALUE
    repeat (3) begin
      tick();
      checkOutput("rst sync rv", syncRv, 3'b101);
      checkOutput("rst rise rv", riseRv, 3'b000);
      checkOutput("rst fall rv", fallRv, 3'b000);
      checkOutput("rst sync def", syncDef, 3'b000);
    end
    resetN = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checkOutput($sformatf("rel sync rv e%0d", e), syncRv, 3'b101);
      checkOutput($sformatf("rel rise rv e%0d", e), riseRv, 3'b000);
      checkOutput($sformatf("rel fall rv e%0d", e), fallRv, 3'b000);
    end

    // Clean rising then falling edge on bit 0
    applyStimulus(1, 3'b001);
    for (int e = 1; e <= LAT_DEF + 2; e++) begin
      tick();
      checkOutput($sformatf("up sync e%0d", e), syncDef, (e >= LAT_DEF) ? 3'b001 : 3'b000);
      checkOutput($sformatf("up rise e%0d", e), riseDef, (e == LAT_DEF) ? 3'b001 : 3'b000);
      checkOutput($sformatf("up fall e%0d", e), fallDef, 3'b000);
    end
    applyStimulus(1, 3'b000);
    for (int e = 1; e <= LAT_DEF + 2; e++) begin
      tick();
      checkOutput($sformatf("dn sync e%0d", e), syncDef, (e >= LAT_DEF) ? 3'b000 : 3'b001);
      checkOutput($sformatf("dn fall e%0d", e), fallDef, (e == LAT_DEF) ? 3'b001 : 3'b000);
      checkOutput($sformatf("dn rise e%0d", e), riseDef, 3'b000);
    end

    // Short glitch and just-long-enough pulse on bit 1
    runPulse(3'b010, 3);
    runPulse(3'b010, 4);

    // Reset asserted mid-count on bit 2, released with input still high
    applyStimulus(1, 3'b100);
    repeat (RST_AT) tick();
    resetN = 1'b0;
    #1;
    checkOutput("midrst sync", syncDef, 3'b000);
    checkOutput("midrst rise", riseDef, 3'b000);
    checkOutput("midrst fall", fallDef, 3'b000);
    tick();
    tick();
    checkOutput("midrst hold sync", syncDef, 3'b000);
    resetN = 1'b1;
    for (int e = 1; e <= LAT_DEF + 3; e++) begin
      tick();
      checkOutput($sformatf("after rst sync e%0d", e), syncDef, (e >= LAT_DEF) ? 3'b100 : 3'b000);
      checkOutput($sformatf("after rst rise e%0d", e), riseDef, (e == LAT_DEF) ? 3'b100 : 3'b000);
      checkOutput($sformatf("after rst fall e%0d", e), fallDef, 3'b000);
    end

    // STAGES=3: bits 0 and 2 toggled together
    applyStimulus(2, 3'b101);
    for (int e = 1; e <= LAT_S3 + 2; e++) begin
      tick();
      checkOutput($sformatf("s3 sync e%0d", e), syncS3, (e >= LAT_S3) ? 3'b101 : 3'b000);
      checkOutput($sformatf("s3 rise e%0d", e), riseS3, (e == LAT_S3) ? 3'b101 : 3'b000);
    end
    applyStimulus(2, 3'b000);
    repeat (LAT_S3 + 3) tick();
    checkOutput("s3 idle sync", syncS3, 3'b000);

    // Gray pointer sequence 0->1->3->2
    applyStimulus(2, grayIn(1));
    for (int e = 1; e <= 3 * GRAY_HOLD + LAT_S3 + 1; e++) begin
      tick();
      applyStimulus(2, grayIn(e + 1));
      expNow  = grayIn(e - (LAT_S3 - 1));
      expPrev = grayIn(e - LAT_S3);
      checkOutput($sformatf("gray sync e%0d", e), syncS3, expNow);
      checkOutput($sformatf("gray rise e%0d", e), riseS3, expNow & ~expPrev);
      checkOutput($sformatf("gray fall e%0d", e), fallS3, ~expNow & expPrev);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sync_filter_array.md
# sync_filter_array

Parametrised multi-bit, multi-stage input synchronizer with a per-bit glitch filter and registered edge-detect pulses. Each bit of an asynchronous bus is captured by an N-flop chain in the destination domain, optionally qualified by a stability counter, and reported both as a level and as single-cycle rise/fall pulses. It is the successor to the fixed two-flop pointer synchronizer. It serves async FIFO pointers, with the filter compiled out, and slow control and status inputs such as `start`, `done` and external flags, with the filter compiled in.

## Interface
Parameters:
- `DATA_WIDTH`, 3: number of independent bits synchronized.
- `STAGES`, 2: flops in the synchronizer chain; must be at least 2.
- `STABLE_CYCLES`, 4: consecutive cycles a synchronized bit must hold a new value before it is accepted; must be at least 1. Used only with the filter.
- `RESET_VALUE`, `'0`: reset value of every chain flop, the filtered level and `sync_data_o`.

Ports (one clock; reset is asynchronous and active-low):
- `dest_clk`  in  1  destination clock.
- `dest_reset_n`  in  1  asynchronous active-low reset.
- `async_data_i`  in  DATA_WIDTH  asynchronous input bus; bits are treated independently.
- `sync_data_o`  out  DATA_WIDTH  synchronized level, filtered when the filter is compiled in; resets to `RESET_VALUE`.
- `rise_o`  out  DATA_WIDTH  one-cycle pulse per bit on a 0->1 change of `sync_data_o`; resets to 0.
- `fall_o`  out  DATA_WIDTH  one-cycle pulse per bit on a 1->0 change of `sync_data_o`; resets to 0.

## Operation
- **Chain.** `chain[0] <= async_data_i`, then `chain[k] <= chain[k-1]`. Call `s = chain[STAGES-1]`.
- **Filter, per bit i.** The bit has a level register `filt[i]` and a counter `cnt[i]` of width `$clog2(STABLE_CYCLES+1)`.
  - If `s[i] == filt[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_CYCLES-1`: `filt[i] <= s[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
- **Filter output.** `sync_data_o = filt`.
- **Edge pulses.** These are registered at the same edge that updates the level.
  - `rise_o[i] <= update[i] & s[i]`.
  - `fall_o[i] <= update[i] & ~s[i]`.
  - `update[i]` is the acceptance condition above.
- **Bit independence.** Bits never interact. No multi-bit coherency is provided, so buses must be gray-coded by the source.
- **Glitch rejection.** A synchronized bit that toggles back before `STABLE_CYCLES` consecutive differing cycles changes nothing. Its counter restarts from 0.
- **STABLE_CYCLES = 1.** Every change is accepted one cycle after it reaches `s`.
- **Reset.** Reset asserted mid-count clears all counters, forces chain and `filt` to `RESET_VALUE`, and clears the pulses. No pulse is generated on reset release.
- **Parameter checks.** `STAGES < 2` or `STABLE_CYCLES < 1` is an elaboration-time `$error`.

## Timing
- Assume an input change is captured at edge 1.
- The change reaches `s` after `STAGES` edges.
- With the filter, `sync_data_o` and the matching pulse update after `STAGES + STABLE_CYCLES` edges. With defaults, that is edge 6.
- Without the filter, the latency is `STAGES` edges and the pulse is coincident with the level change.
- Pulses are exactly one `dest_clk` cycle wide.
- Two level changes on one bit produce pulses at least `STABLE_CYCLES` cycles apart with the filter, or 1 cycle apart without it.

## Configuration
- **`SYNC_GLITCH_FILTER_EN` defined:** the filter, counters and `filt` registers are built as above.
- **`SYNC_GLITCH_FILTER_EN` undefined:**
  - No counters are built.
  - `sync_data_o = s`.
  - `rise_o[i] <= chain[STAGES-2][i] & ~s[i]`.
  - `fall_o[i] <= ~chain[STAGES-2][i] & s[i]`.
  - `STABLE_CYCLES` is ignored.
  - Reset values and pulse width are unchanged.

## Structure
- **Package `sync_pkg`:**
  - Default constants `SYNC_DEF_STAGES = 2` and `SYNC_DEF_STABLE = 4`.
  - Function `sync_cnt_w(stable)` returning the counter width.
- **Sub-module `sync_bit_filter`:** one instance per bit, generated over `DATA_WIDTH`. It holds `cnt`, `filt`, `rise` and `fall` for one bit and is excluded by the macro.
- **Top level:** the chain and the parameter checks stay in `sync_filter_array`.

## Test plan
- **Reset values.** Set `RESET_VALUE = 3'b101` and hold reset for 3 cycles, then release. Required: `sync_data_o = 3'b101`, no pulses, and `async_data_i = 3'b101` held afterwards produces no pulse.
- **Clean edge, filter on, defaults.** Drive `async_data_i` 000 -> 001 at edge 1. Required: `sync_data_o = 001` and `rise_o = 001` for exactly one cycle at edge 6. Returning the input to 000 later gives `fall_o = 001` six edges after the change.
- **Glitch.** Pulse bit 1 high for 3 cycles with `STABLE_CYCLES = 4`. Required: `sync_data_o` stays 000 and no pulses. A 4-cycle pulse produces a rise followed by a fall exactly 4 cycles later.
- **Reset mid-count.** Bit 2 goes high; assert reset after `cnt = 2`, then release with the input still high. Required: outputs are 0 during reset. Acceptance occurs `STAGES + STABLE_CYCLES` edges after release, with one `rise_o` only.
- **Filter off, `STAGES = 3`, independent bits.** Toggle bits 0 and 2 in the same cycle. Required: both change on `sync_data_o` at edge 3, with coincident `rise_o = 101` for one cycle. Gray pointer sequence 0->1->3->2 is reproduced in order, 3 cycles delayed.
